// File: rtl/pingpong_bank_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl
//
// Double-buffer bank controller.  A writer fills one bank of DEPTH words
// while a reader drains the other.  When the writer completes a bank, that
// bank is marked full, handed to the reader and the write side flips to the
// opposite bank.  When the reader pulses rd_done the bank it owns is
// released (marked empty) and the read side flips.
//
// Per-bank life cycle:
//   state   | meaning
//   EMPTY   | bank_full=0, not the write bank or write bank with wr_addr=0
//   FILLING | write bank, 0 < wr_addr <= DEPTH-1
//   FULL    | bank_full=1, owned by the reader until released
//
// Parameters
//   ADDR_W      bank address width, DEPTH = 2**ADDR_W words per bank
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   wr_valid    writer offers a word
//   wr_ready    current write bank can accept a word
//   wr_en       write strobe to bank RAM (wr_valid & wr_ready)
//   wr_addr     word address within the current write bank
//   toggle      one-hot write-bank select (01 = bank 0, 10 = bank 1)
//   rd_bank     one-hot read-bank select, same encoding
//   rd_valid    bank selected by rd_bank is full and owned by the reader
//   rd_done     one-cycle pulse, reader has finished the current read bank
//   bank_full   per-bank full flags, bit 0 = bank 0
//   err         sticky protocol-error flag
//
// Build option
//   PINGPONG_ERR_EN  when defined, err latches on an overrun attempt
//                    (wr_valid while !wr_ready) or a spurious release
//                    (rd_done while !rd_valid).  When undefined err is 0
//                    and no detection logic exists.
// ---------------------------------------------------------------------------
module pingpong_bank_ctrl #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        toggle,
    output logic [1:0]        rd_bank,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic [1:0]        bank_full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [1:0]        SEL_BANK0 = 2'b01;

    logic [1:0]        toggle_q,    toggle_d;
    logic [1:0]        rd_bank_q,   rd_bank_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [1:0]        bank_full_q, bank_full_d;

    logic wr_accept;
    logic wr_last;
    logic rd_release;

    // Handshake and read-side status.  Only wr_en sees inputs; wr_ready
    // additionally masks itself during reset so no write is acknowledged
    // on a cycle whose state update is being discarded.
    assign wr_ready   = !rst && !(|(bank_full_q & toggle_q));
    assign wr_accept  = wr_valid && wr_ready;
    assign wr_last    = wr_accept && (wr_addr_q == LAST_ADDR);
    assign rd_valid   = |(bank_full_q & rd_bank_q);
    assign rd_release = rd_done && rd_valid;

    always_comb begin
        toggle_d    = toggle_q;
        rd_bank_d   = rd_bank_q;
        wr_addr_d   = wr_addr_q;
        bank_full_d = bank_full_q;

        if (wr_accept) begin
            if (wr_last) begin
                wr_addr_d   = '0;
                toggle_d    = {toggle_q[0], toggle_q[1]};
                bank_full_d = bank_full_d | toggle_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // Applied after the fill so that a release of the same bank would
        // take precedence (cannot happen, a full bank refuses writes).
        if (rd_release) begin
            bank_full_d = bank_full_d & ~rd_bank_q;
            rd_bank_d   = {rd_bank_q[0], rd_bank_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q    <= SEL_BANK0;
            rd_bank_q   <= SEL_BANK0;
            wr_addr_q   <= '0;
            bank_full_q <= 2'b00;
        end else begin
            toggle_q    <= toggle_d;
            rd_bank_q   <= rd_bank_d;
            wr_addr_q   <= wr_addr_d;
            bank_full_q <= bank_full_d;
        end
    end

`ifdef PINGPONG_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((wr_valid && !wr_ready) || (rd_done && !rd_valid)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wr_en     = wr_accept;
    assign wr_addr   = wr_addr_q;
    assign toggle    = toggle_q;
    assign rd_bank   = rd_bank_q;
    assign bank_full = bank_full_q;

endmodule
